// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse position tracker: status bit indices,
// delta/sum widths and the FSM state encoding.
package mouse_pkg;

  localparam int DELTA_W = 9;
  localparam int SUM_W   = DELTA_W + 1;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int OVF_X = 6;
  localparam int OVF_Y = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCALE,
    ST_SUM,
    ST_LIMIT,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/mouse_axis_limit.sv
// Per-axis limiter: brings a 10-bit signed sum into 0..MAX. Clamps in one step by
// default; with MOUSE_TRACKER_WRAP_EN defined it wraps by one span per step.
module mouse_axis_limit
  import mouse_pkg::*;
#(
  parameter int MAX = 159
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic signed [SUM_W-1:0] next,
  output logic                    done
);

  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);

`ifdef MOUSE_TRACKER_WRAP_EN
  localparam logic signed [SUM_W-1:0] SPAN_S = SUM_W'(MAX + 1);

  // done reflects the current value, so an out-of-range sum costs one extra cycle per step
  always_comb begin
    next = sum;
    done = 1'b1;
    if (sum < 0) begin
      next = sum + SPAN_S;
      done = 1'b0;
    end else if (sum > MAX_S) begin
      next = sum - SPAN_S;
      done = 1'b0;
    end
  end
`else
  always_comb begin
    next = sum;
    done = 1'b1;
    if (sum < 0) begin
      next = '0;
    end else if (sum > MAX_S) begin
      next = MAX_S;
    end
  end
`endif

endmodule

// File: rtl/mouse_position_tracker.sv
// Integrates PS/2 mouse packet deltas into a bounded cursor position, with a
// one-slot pending buffer and a SET override. MOUSE_TRACKER_WRAP_EN selects wrapping.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int MAX_X    = 159,
  parameter int MAX_Y    = 119,
  parameter int INIT_X   = 80,
  parameter int INIT_Y   = 60,
  parameter int SHIFT    = 0,
  parameter int INVERT_Y = 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               PKT_VALID,
  input  logic [7:0]         PKT_STATUS,
  input  logic [DELTA_W-1:0] PKT_DX,
  input  logic [DELTA_W-1:0] PKT_DY,
  input  logic               SET_EN,
  input  logic [7:0]         SET_X,
  input  logic [7:0]         SET_Y,
  output logic [7:0]         POS_X,
  output logic [7:0]         POS_Y,
  output logic [2:0]         BUTTONS,
  output logic               UPDATED,
  output logic               DROPPED,
  output logic               BUSY
);

  localparam logic [7:0] MAX_X8  = 8'(MAX_X);
  localparam logic [7:0] MAX_Y8  = 8'(MAX_Y);
  localparam logic [7:0] INIT_X8 = 8'(INIT_X);
  localparam logic [7:0] INIT_Y8 = 8'(INIT_Y);

  state_t state_reg, state_next;

  logic [7:0]               cur_status_reg, pend_status_reg;
  logic [DELTA_W-1:0]       cur_dx_reg, cur_dy_reg, pend_dx_reg, pend_dy_reg;
  logic                     pend_valid_reg;
  logic signed [SUM_W-1:0]  dx_reg, dy_reg, sx_reg, sy_reg;
  logic [7:0]               pos_x_reg, pos_y_reg;
  logic [2:0]               buttons_reg;
  logic                     updated_reg, dropped_reg;

  logic signed [SUM_W-1:0]  dx_ext, dy_ext, dx_scaled, dy_shifted, dy_scaled;
  logic signed [SUM_W-1:0]  sum_x, sum_y, next_x, next_y;
  logic                     done_x, done_y;
  logic [7:0]               set_x_lim, set_y_lim;
  logic                     unused_status;

  assign unused_status = ^cur_status_reg[5:3];

  // Scale stage: sign-extend, divide, orient Y, then squash overflowed axes
  always_comb begin
    dx_ext     = {cur_dx_reg[DELTA_W-1], cur_dx_reg};
    dy_ext     = {cur_dy_reg[DELTA_W-1], cur_dy_reg};
    dx_scaled  = dx_ext >>> SHIFT;
    dy_shifted = dy_ext >>> SHIFT;
    dy_scaled  = (INVERT_Y != 0) ? -dy_shifted : dy_shifted;
    if (cur_status_reg[OVF_X]) dx_scaled = '0;
    if (cur_status_reg[OVF_Y]) dy_scaled = '0;
  end

  assign sum_x = $signed({2'b00, pos_x_reg}) + dx_reg;
  assign sum_y = $signed({2'b00, pos_y_reg}) + dy_reg;

  assign set_x_lim = (SET_X > MAX_X8) ? MAX_X8 : SET_X;
  assign set_y_lim = (SET_Y > MAX_Y8) ? MAX_Y8 : SET_Y;

  mouse_axis_limit #(.MAX(MAX_X)) u_limit_x (
    .sum  (sx_reg),
    .next (next_x),
    .done (done_x)
  );

  mouse_axis_limit #(.MAX(MAX_Y)) u_limit_y (
    .sum  (sy_reg),
    .next (next_y),
    .done (done_y)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (pend_valid_reg || PKT_VALID) state_next = ST_SCALE;
      ST_SCALE:  state_next = ST_SUM;
      ST_SUM:    state_next = ST_LIMIT;
      ST_LIMIT:  if (done_x && done_y) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (SET_EN) state_next = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_status_reg  <= '0;
      cur_dx_reg      <= '0;
      cur_dy_reg      <= '0;
      pend_status_reg <= '0;
      pend_dx_reg     <= '0;
      pend_dy_reg     <= '0;
      pend_valid_reg  <= 1'b0;
      dx_reg          <= '0;
      dy_reg          <= '0;
      sx_reg          <= '0;
      sy_reg          <= '0;
      pos_x_reg       <= INIT_X8;
      pos_y_reg       <= INIT_Y8;
      buttons_reg     <= '0;
      updated_reg     <= 1'b0;
      dropped_reg     <= 1'b0;
    end else begin
      updated_reg <= 1'b0;
      dropped_reg <= 1'b0;
      if (SET_EN) begin
        pos_x_reg      <= set_x_lim;
        pos_y_reg      <= set_y_lim;
        pend_valid_reg <= 1'b0;
        updated_reg    <= 1'b1;
        dropped_reg    <= (state_reg != ST_IDLE) || pend_valid_reg || PKT_VALID;
      end else begin
        // Intake: IDLE drains the slot first; a strobe arriving then refills it
        if (state_reg == ST_IDLE) begin
          if (pend_valid_reg) begin
            cur_status_reg <= pend_status_reg;
            cur_dx_reg     <= pend_dx_reg;
            cur_dy_reg     <= pend_dy_reg;
            pend_valid_reg <= PKT_VALID;
            if (PKT_VALID) begin
              pend_status_reg <= PKT_STATUS;
              pend_dx_reg     <= PKT_DX;
              pend_dy_reg     <= PKT_DY;
            end
          end else if (PKT_VALID) begin
            cur_status_reg <= PKT_STATUS;
            cur_dx_reg     <= PKT_DX;
            cur_dy_reg     <= PKT_DY;
          end
        end else if (PKT_VALID) begin
          pend_status_reg <= PKT_STATUS;
          pend_dx_reg     <= PKT_DX;
          pend_dy_reg     <= PKT_DY;
          pend_valid_reg  <= 1'b1;
          dropped_reg     <= pend_valid_reg;
        end

        case (state_reg)
          ST_SCALE: begin
            dx_reg <= dx_scaled;
            dy_reg <= dy_scaled;
          end
          ST_SUM: begin
            sx_reg <= sum_x;
            sy_reg <= sum_y;
          end
          ST_LIMIT: begin
            sx_reg <= next_x;
            sy_reg <= next_y;
          end
          ST_COMMIT: begin
            pos_x_reg   <= sx_reg[7:0];
            pos_y_reg   <= sy_reg[7:0];
            buttons_reg <= cur_status_reg[BTN_M:BTN_L];
            updated_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign POS_X   = pos_x_reg;
  assign POS_Y   = pos_y_reg;
  assign BUTTONS = buttons_reg;
  assign UPDATED = updated_reg;
  assign DROPPED = dropped_reg;
  assign BUSY    = (state_reg != ST_IDLE);

endmodule
